// File: rtl/sram_bist_master_pkg.sv
// Shared definitions for the RTAP-side SRAM BIST debug-bus master.
// Holds the BIST command encodings, bus widths and the master FSM state type.
package sram_bist_master_pkg;

  localparam int unsigned BIST_OP_WIDTH          = 3;
  localparam int unsigned SRAM_WRAPPER_BUS_WIDTH = 4;
  localparam int unsigned JTAG_DATA_REQ_WIDTH    = 192;
  localparam int unsigned JTAG_DATA_RES_WIDTH    = 256;

  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_NOP           = 3'd0;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_SHIFT_ID      = 3'd1;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_SHIFT_BSEL    = 3'd2;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_SHIFT_ADDRESS = 3'd3;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_SHIFT_DATA    = 3'd4;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_READ          = 3'd5;
  localparam logic [BIST_OP_WIDTH-1:0] BIST_OP_WRITE         = 3'd6;

  typedef enum logic [3:0] {
    IDLE, SH_ID, SH_BSEL, SH_ADDR, OP, RD_WAIT, RD_SHIFT, RD_LAST,
    WR_SHIFT, WR_DRAIN, RESP
  } bist_state_t;

  // Bus command driven for the whole time the FSM sits in a state.
  function automatic logic [BIST_OP_WIDTH-1:0] state_cmd(bist_state_t s);
    unique case (s)
      SH_ID:              return BIST_OP_SHIFT_ID;
      SH_BSEL:            return BIST_OP_SHIFT_BSEL;
      SH_ADDR:            return BIST_OP_SHIFT_ADDRESS;
      OP:                 return BIST_OP_READ;
      RD_SHIFT, WR_SHIFT: return BIST_OP_SHIFT_DATA;
      default:            return BIST_OP_NOP;
    endcase
  endfunction

  // States whose data nibbles come from the TX shift register.
  function automatic logic state_streams(bist_state_t s);
    return (s == SH_ID) || (s == SH_BSEL) || (s == SH_ADDR) || (s == WR_SHIFT);
  endfunction

endpackage

// File: rtl/sram_bist_master_shifter.sv
// bist_nibble_shifter: parallel-load, MSB-first nibble shift register.
// Ports: clk, rst (sync, active-high), load/load_value (parallel load, wins
// over shift), shift/nib_in (shift left one nibble, nib_in enters at the LSB),
// value (current register contents; top nibble is the next one to send).
module bist_nibble_shifter
  import sram_bist_master_pkg::*;
#(
  parameter int unsigned WIDTH = 224
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [WIDTH-1:0]                  load_value,
  input  logic                              shift,
  input  logic [SRAM_WRAPPER_BUS_WIDTH-1:0] nib_in,
  output logic [WIDTH-1:0]                  value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (shift) begin
      value <= {value[WIDTH-SRAM_WRAPPER_BUS_WIDTH-1:0], nib_in};
    end
  end

endmodule

// File: rtl/sram_bist_master.sv
// sram_bist_master: serialises one read/write request onto the nibble-wide
// SRAM wrapper BIST bus and, for reads, collects the 64-nibble response.
// Ports: clk, rst (sync, active-high); req_* request handshake and fields;
// rsp_* response handshake and read data; bist_command/bist_data drive the
// broadcast BIST bus; bist_rdata is the returned read nibble stream.
module sram_bist_master
  import sram_bist_master_pkg::*;
#(
  parameter int unsigned WR_NIBBLES = 48,
  parameter int unsigned RD_NIBBLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [7:0]                        req_id,
  input  logic [7:0]                        req_bsel,
  input  logic [15:0]                       req_addr,
  input  logic [JTAG_DATA_REQ_WIDTH-1:0]    req_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [JTAG_DATA_RES_WIDTH-1:0]    rsp_rdata,
  output logic [BIST_OP_WIDTH-1:0]          bist_command,
  output logic [SRAM_WRAPPER_BUS_WIDTH-1:0] bist_data,
  input  logic [SRAM_WRAPPER_BUS_WIDTH-1:0] bist_rdata
);

  localparam int unsigned TX_WIDTH = 32 + JTAG_DATA_REQ_WIDTH;

  bist_state_t state, nxt_state;
  logic [5:0]  cnt;
  logic        is_write;
  logic        accept;
  logic        tx_shift, rx_shift;
  logic [TX_WIDTH-1:0]            tx_value;
  logic [TX_WIDTH-1:0]            tx_load_value;
  logic [SRAM_WRAPPER_BUS_WIDTH-1:0] tx_top;

  // Cycles spent in a state, minus one.
  function automatic logic [5:0] state_len(bist_state_t s);
    unique case (s)
      SH_ID, SH_BSEL, WR_DRAIN: return 6'd1;
      SH_ADDR:                  return 6'd3;
      RD_SHIFT:                 return 6'(RD_NIBBLES - 2);
      WR_SHIFT:                 return 6'(WR_NIBBLES - 1);
      default:                  return 6'd0;
    endcase
  endfunction

  assign accept = req_valid && req_ready;

  // The first ID nibble goes straight to bist_data on acceptance, so the TX
  // register is loaded already advanced by one nibble (zero pad at the LSB).
  assign tx_load_value = {req_id[3:0], req_bsel, req_addr, req_wdata, 4'h0};
  assign tx_top        = tx_value[TX_WIDTH-1 -: SRAM_WRAPPER_BUS_WIDTH];
  assign tx_shift      = state_streams(state);
  assign rx_shift      = (state == RD_SHIFT) || (state == RD_LAST);

  bist_nibble_shifter #(.WIDTH(TX_WIDTH)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (tx_load_value),
    .shift      (tx_shift),
    .nib_in     ('0),
    .value      (tx_value)
  );

  // Cleared on every acceptance, so a write response reads back as zero.
  bist_nibble_shifter #(.WIDTH(JTAG_DATA_RES_WIDTH)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value ('0),
    .shift      (rx_shift),
    .nib_in     (bist_rdata),
    .value      (rsp_rdata)
  );

  always_comb begin
    nxt_state = state;
    unique case (state)
      SH_ID:    nxt_state = SH_BSEL;
      SH_BSEL:  nxt_state = SH_ADDR;
      SH_ADDR:  nxt_state = is_write ? WR_SHIFT : OP;
      OP:       nxt_state = RD_WAIT;
      RD_WAIT:  nxt_state = RD_SHIFT;
      RD_SHIFT: nxt_state = RD_LAST;
      RD_LAST:  nxt_state = RESP;
      WR_SHIFT: nxt_state = WR_DRAIN;
      WR_DRAIN: nxt_state = RESP;
      default:  nxt_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      is_write     <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      bist_command <= BIST_OP_NOP;
      bist_data    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state        <= SH_ID;
            cnt          <= state_len(SH_ID);
            is_write     <= req_write;
            req_ready    <= 1'b0;
            bist_command <= BIST_OP_SHIFT_ID;
            bist_data    <= req_id[7:4];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          if (cnt != 6'd0) begin
            cnt       <= cnt - 6'd1;
            bist_data <= state_streams(state) ? tx_top : '0;
          end else begin
            state        <= nxt_state;
            cnt          <= state_len(nxt_state);
            bist_command <= state_cmd(nxt_state);
            bist_data    <= state_streams(nxt_state) ? tx_top : '0;
            rsp_valid    <= (nxt_state == RESP);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist_master.sv
module tb_sram_bist_master;
  import sram_bist_master_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [7:0]   req_id = '0;
  logic [7:0]   req_bsel = '0;
  logic [15:0]  req_addr = '0;
  logic [191:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [255:0] rsp_rdata;
  logic [2:0]   bist_command;
  logic [3:0]   bist_data;
  logic [3:0]   bist_rdata;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  sram_bist_master #(.WR_NIBBLES(48), .RD_NIBBLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_id       (req_id),
    .req_bsel     (req_bsel),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .bist_command (bist_command),
    .bist_data    (bist_data),
    .bist_rdata   (bist_rdata)
  );

  // Behavioural dp_ram target, SR_ID=0x3A, ADDR_WIDTH=6, DATA_WIDTH=64.
  logic [63:0]  mem [64];
  logic [7:0]   t_id = '0;
  logic [15:0]  t_addr = '0;
  logic [191:0] t_wsr = '0;
  int unsigned  t_wcnt = 0;
  logic [255:0] t_rsr = '0;
  logic         t_rd_active = 1'b0;
  logic         t_rd_hold = 1'b0;
  int unsigned  t_hits = 0;
  logic         pl_en = 1'b0;
  logic [5:0]   pl_addr = '0;
  logic [63:0]  pl_data = '0;

  assign bist_rdata = t_rd_active ? t_rsr[255:252] : 4'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    case (bist_command)
      BIST_OP_NOP: begin
        if (t_rd_hold) begin
          t_rd_hold <= 1'b0;
        end else begin
          if (t_id == 8'h3A && t_wcnt == 48) begin
            mem[t_addr[5:0]] <= t_wsr[63:0];
            t_hits <= t_hits + 1;
          end
          t_id <= '0;
          t_addr <= '0;
          t_wcnt <= 0;
          t_rd_active <= 1'b0;
        end
      end
      BIST_OP_SHIFT_ID:      t_id <= {t_id[3:0], bist_data};
      BIST_OP_SHIFT_ADDRESS: t_addr <= {t_addr[11:0], bist_data};
      BIST_OP_READ: begin
        if (t_id == 8'h3A) begin
          t_rsr <= {192'h0, mem[t_addr[5:0]]};
          t_rd_active <= 1'b1;
          t_rd_hold <= 1'b1;
          t_hits <= t_hits + 1;
        end
      end
      BIST_OP_SHIFT_DATA: begin
        if (t_rd_active) begin
          t_rsr <= {t_rsr[251:0], 4'h0};
        end else if (t_id == 8'h3A) begin
          t_wsr <= {t_wsr[187:0], bist_data};
          t_wcnt <= t_wcnt + 1;
        end
      end
      default: ;
    endcase
  end

  logic [2:0] cmd_log [0:127];
  logic [3:0] data_log [0:127];
  int         rsp_k;

  task automatic preload(input logic [5:0] a, input logic [63:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request from a negedge; logs cycles A+1.. until rsp_valid.
  task automatic do_req(input logic wr, input logic [7:0] id, input logic [15:0] addr,
                        input logic [191:0] wd);
    int unsigned guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = wr; req_id = id; req_bsel = 8'h5C;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_k = 0;
    for (int k = 1; k < 128; k++) begin
      @(negedge clk);
      cmd_log[k] = bist_command;
      data_log[k] = bist_data;
      if (rsp_valid) begin rsp_k = k; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (rsp_rdata !== 256'h0 || rsp_valid !== 1'b0 || bist_data !== 4'h0) begin
      bad++; $display("FAIL reset_outputs: rsp_valid=%b data=%h rdata=%h want 0", rsp_valid, bist_data, rsp_rdata);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bist_command !== BIST_OP_NOP || req_ready !== 1'b1) begin
        bad++; $display("FAIL idle_cycle%0d: cmd=%0d ready=%b want 0/1", i, bist_command, req_ready);
      end
    end
  endtask

  task automatic test_read();
    preload(6'h12, 64'hDEADBEEF_01234567);
    do_req(1'b0, 8'h3A, 16'h0012, 192'h0);
    total++; if (rsp_k !== 75) begin bad++; $display("FAIL rd_latency: got A+%0d want A+75", rsp_k); end
    total++; if (rsp_rdata !== {192'h0, 64'hDEADBEEF_01234567}) begin
      bad++; $display("FAIL rd_data: got %h want %h", rsp_rdata, {192'h0, 64'hDEADBEEF_01234567}); end
    total++; if (cmd_log[1] !== BIST_OP_SHIFT_ID || data_log[1] !== 4'h3 || data_log[2] !== 4'hA) begin
      bad++; $display("FAIL rd_id_stream: got cmd=%0d %h%h want 1 3a", cmd_log[1], data_log[1], data_log[2]); end
    total++; if (cmd_log[3] !== BIST_OP_SHIFT_BSEL || data_log[3] !== 4'h5 || data_log[4] !== 4'hC) begin
      bad++; $display("FAIL rd_bsel_stream: got cmd=%0d %h%h want 2 5c", cmd_log[3], data_log[3], data_log[4]); end
    total++; if (cmd_log[5] !== BIST_OP_SHIFT_ADDRESS || cmd_log[8] !== BIST_OP_SHIFT_ADDRESS ||
                 {data_log[5], data_log[6], data_log[7], data_log[8]} !== 16'h0012) begin
      bad++; $display("FAIL rd_addr_stream: got cmd=%0d addr=%h%h%h%h want 3 0012", cmd_log[5],
                      data_log[5], data_log[6], data_log[7], data_log[8]); end
    total++; if (cmd_log[9] !== BIST_OP_READ || cmd_log[10] !== BIST_OP_NOP) begin
      bad++; $display("FAIL rd_op: got %0d,%0d want 5,0", cmd_log[9], cmd_log[10]); end
    total++; if (cmd_log[11] !== BIST_OP_SHIFT_DATA || cmd_log[73] !== BIST_OP_SHIFT_DATA || cmd_log[74] !== BIST_OP_NOP) begin
      bad++; $display("FAIL rd_shift: got %0d,%0d,%0d want 4,4,0", cmd_log[11], cmd_log[73], cmd_log[74]); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bist_command !== BIST_OP_NOP) begin
      bad++; $display("FAIL rd_return_idle: got valid=%b ready=%b cmd=%0d want 0 1 0", rsp_valid, req_ready, bist_command); end
  endtask

  task automatic test_write();
    logic [191:0] wd;
    wd = 192'h0123456789ABCDEF_FEDCBA9876543210_0BADF00D1234CAFE;
    do_req(1'b1, 8'h3A, 16'h0005, wd);
    total++; if (rsp_k !== 59) begin bad++; $display("FAIL wr_latency: got A+%0d want A+59", rsp_k); end
    total++; if (rsp_rdata !== 256'h0) begin bad++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata); end
    total++; if (cmd_log[9] !== BIST_OP_SHIFT_DATA || data_log[9] !== 4'h0 || data_log[10] !== 4'h1 ||
                 cmd_log[56] !== BIST_OP_SHIFT_DATA || data_log[56] !== 4'hE) begin
      bad++; $display("FAIL wr_stream: got %0d:%h%h .. %0d:%h want 4:01 .. 4:e", cmd_log[9], data_log[9],
                      data_log[10], cmd_log[56], data_log[56]); end
    total++; if (cmd_log[57] !== BIST_OP_NOP || cmd_log[58] !== BIST_OP_NOP) begin
      bad++; $display("FAIL wr_drain: got %0d,%0d want 0,0", cmd_log[57], cmd_log[58]); end
    @(negedge clk);
    total++; if (mem[5] !== 64'h0BADF00D1234CAFE) begin
      bad++; $display("FAIL wr_mem: got %h want 0badf00d1234cafe", mem[5]); end
    do_req(1'b0, 8'h3A, 16'h0005, 192'h0);
    total++; if (rsp_k !== 75 || rsp_rdata !== {192'h0, 64'h0BADF00D1234CAFE}) begin
      bad++; $display("FAIL wr_readback: got A+%0d %h want A+75 0badf00d1234cafe", rsp_k, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_id_mismatch();
    int unsigned hits0;
    hits0 = t_hits;
    do_req(1'b0, 8'h3B, 16'h0012, 192'h0);
    total++; if (rsp_k !== 75 || rsp_rdata !== 256'h0) begin
      bad++; $display("FAIL mis_rdata: got A+%0d %h want A+75 0", rsp_k, rsp_rdata); end
    total++; if (t_hits !== hits0 || mem[6'h12] !== 64'hDEADBEEF_01234567) begin
      bad++; $display("FAIL mis_target: got hits=%0d mem=%h want %0d deadbeef01234567", t_hits, mem[6'h12], hits0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    preload(6'h07, 64'h7777_0000_1111_2222);
    req_valid = 1'b1; req_write = 1'b1; req_id = 8'h3A; req_addr = 16'h0007;
    req_wdata = {3{64'h1234_5678_9ABC_DEF0}};
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) @(negedge clk);
    total++; if (bist_command !== BIST_OP_SHIFT_DATA) begin
      bad++; $display("FAIL mid_wr_active: got cmd=%0d want 4", bist_command); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bist_command !== BIST_OP_NOP || bist_data !== 4'h0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_wr_reset: got cmd=%0d data=%h ready=%b valid=%b want 0 0 1 0",
                      bist_command, bist_data, req_ready, rsp_valid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem[7] !== 64'h7777_0000_1111_2222) begin
      bad++; $display("FAIL mid_wr_mem: got %h want 7777000011112222", mem[7]); end
    do_req(1'b0, 8'h3A, 16'h0007, 192'h0);
    total++; if (rsp_k !== 75 || rsp_rdata !== {192'h0, 64'h7777_0000_1111_2222}) begin
      bad++; $display("FAIL mid_wr_next_req: got A+%0d %h want A+75 7777000011112222", rsp_k, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] held;
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h3A, 16'h0005, 192'h0);
    held = rsp_rdata;
    total++; if (rsp_k !== 75 || held !== {192'h0, 64'h0BADF00D1234CAFE}) begin
      bad++; $display("FAIL hold_first: got A+%0d %h want A+75 0badf00d1234cafe", rsp_k, held); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b rdata=%h want 1 0 %h", i, rsp_valid,
                        req_ready, rsp_rdata, held); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bist_command !== BIST_OP_NOP) begin
      bad++; $display("FAIL b2b_gap: got valid=%b ready=%b cmd=%0d want 0 1 0", rsp_valid, req_ready, bist_command); end
    do_req(1'b0, 8'h3A, 16'h0012, 192'h0);
    total++; if (cmd_log[1] !== BIST_OP_SHIFT_ID || rsp_k !== 75 || rsp_rdata !== {192'h0, 64'hDEADBEEF_01234567}) begin
      bad++; $display("FAIL b2b_second: got cmd=%0d A+%0d %h want 1 A+75 deadbeef01234567", cmd_log[1], rsp_k, rsp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_id_mismatch();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bist_master.md
Name: sram_bist_master

Overview:
- RTAP-side driver for the SRAM wrapper BIST debug bus.
- Takes one read or write request: target SRAM ID, address, and 192-bit write data.
- Serialises it into the nibble-wide command/data stream the dp_ram BIST FSM expects, driving rtap_srams_bist_command and rtap_srams_bist_data.
- For reads, deserialises 64 nibbles from srams_rtap_data into a 256-bit response.
- Sits between the JTAG/RTAP request decoder and the broadcast SRAM BIST bus.

Parameters:
- WR_NIBBLES, 48, nibbles shifted for a write; equals JTAG_DATA_REQ_WIDTH/4.
- RD_NIBBLES, 64, nibbles captured for a read; equals JTAG_DATA_RES_WIDTH/4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_id  in  8  target SR_ID
- req_bsel  in  8  bit-select field, shifted but unused by the target
- req_addr  in  16  SRAM address
- req_wdata  in  192  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_rdata  out  256  read data; 0 for writes
- bist_command  out  BIST_OP_WIDTH  to rtap_srams_bist_command
- bist_data  out  SRAM_WRAPPER_BUS_WIDTH  to rtap_srams_bist_data
- bist_rdata  in  SRAM_WRAPPER_BUS_WIDTH  from srams_rtap_data

Behaviour:
- Reset values: bist_command=BIST_OP_NOP, bist_data=0, req_ready=1, rsp_valid=0, rsp_rdata=0, counter=0, state IDLE.
- All bus outputs are registered. A cycle with no stream activity drives NOP with data 0.
- Acceptance: a request is accepted on cycle A when req_valid && req_ready. Fields are latched into shift registers; req_ready drops at A+1.
- Header stream, every nibble MSB-first:
  - A+1..A+2: SHIFT_ID, req_id[7:4] then req_id[3:0]
  - A+3..A+4: SHIFT_BSEL, 2 nibbles
  - A+5..A+8: SHIFT_ADDRESS, 4 nibbles
- Read sequence:
  - A+9: drive READ.
  - A+10: drive NOP; the target performs the SRAM read in this cycle.
  - A+11..A+73: drive SHIFT_DATA (RD_NIBBLES-1 = 63 cycles).
  - Sample bist_rdata every cycle A+11..A+74 (64 samples), shifting into rsp_rdata from the LSB. The first sample lands in bits 255:252.
  - A+74: drive NOP.
  - A+75: rsp_valid=1.
- Write sequence:
  - A+9..A+56: drive SHIFT_DATA with req_wdata nibbles 47..0 (48 cycles, MSB first).
  - A+57..A+58: drive NOP; the target commits the write at A+58.
  - A+59: rsp_valid=1, rsp_rdata=0.
- States: IDLE, SH_ID, SH_BSEL, SH_ADDR, OP, RD_WAIT, RD_SHIFT, RD_LAST, WR_SHIFT, WR_DRAIN, RESP.
- Counter: one 6-bit down-counter is reloaded on each state entry and never wraps.
- Response handshake:
  - RESP holds rsp_valid and rsp_rdata stable until rsp_ready.
  - Returns to IDLE the cycle after the handshake; req_ready=1 in that IDLE cycle.
  - rsp_ready=1 on the same cycle rsp_valid rises completes in 1 cycle.
- Back-to-back requests: at least one IDLE cycle (bus at NOP) always separates requests, so the target returns to its IDLE.
- req_valid while busy: ignored. There is no queue; the upstream must hold req_valid.
- Reset mid-operation: outputs revert to NOP the next cycle and any partial rsp_rdata is discarded. The target aborts on NOP, except in READ_SRAM/WRITE_SRAM, which self-complete within 1 cycle.
- A mid-write reset never reaches WRITE_SRAM unless all 48 nibbles were already sent.
- No ID-mismatch detection: if no SRAM matches, a read returns all zeros.

Decomposition:
- Shared header holds BIST_OP_* encodings (including a new BIST_OP_NOP = 0), BIST_OP_WIDTH, SRAM_WRAPPER_BUS_WIDTH, and JTAG_DATA_REQ/RES_WIDTH.
- One natural sub-module, bist_nibble_shifter: a parallel-load, MSB-first nibble shift register with capture mode. It is instantiated twice, for the TX header/wdata and for RX rdata.

Test Plan:
- Reset then idle: bist_command stays NOP and req_ready=1 for 10 cycles.
- Read with id=0x3A, addr=0x0012 against dp_ram(SR_ID=0x3A, ADDR_WIDTH=6) preloaded at 0x12 with 64'hDEADBEEF_01234567: rsp_valid at A+75, rsp_rdata[63:0] matches, other bits 0.
- Write with id=0x3A, addr=5, wdata=192'h...CAFE, then a read of addr 5: the read returns 0x...CAFE truncated to DATA_WIDTH, and the write rsp_valid is at A+59.
- Read with id=0x3B to a 0x3A target: the target stays IDLE, rsp_rdata=0, and SRAM contents are unchanged.
- rst asserted at A+30 of a write: bist_command=NOP at A+31, the target memory word is unchanged, and a new request is accepted afterwards.
- rsp_ready held low for 5 cycles: rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, and a back-to-back request follows with an IDLE gap.
